mem_stage: RTL
==============

Name: mem_stage

Overview:
MEM stage of the 5-stage MIPS pipeline. Sits between EX and WB.
- Waits for the data-SRAM response of loads/stores issued in EX.
- Extracts and merges load data; produces the bus consumed by WB.
- Drives forwarding and blocking info back to ID.
- Discards in-flight responses belonging to instructions killed by a WB exception or ERET flush.

Parameters:
ES_TO_MS_BUS_WD, 147, EX-to-MEM bus width
MS_TO_WS_BUS_WD, 111, MEM-to-WB bus width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  WB exception or ERET this cycle; kills MEM content
ms_allowin  out  1  MEM can accept from EX
es_to_ms_valid  in  1  EX has a valid instruction
es_to_ms_bus  in  ES_TO_MS_BUS_WD  {load_op[2:0], wait_resp, ex, excode[4:0], badvaddr[31:0], dest[4:0], gr_strb[3:0], alu_result[31:0], rt_value[31:0], pc[31:0]}, MSB first
es_req_fire  in  1  EX data request accepted this cycle (req & addr_ok)
ms_req_stall  out  1  EX must not issue a data request
data_sram_data_ok  in  1  data response valid
data_sram_rdata  in  32  response data
ws_allowin  in  1  WB can accept
ms_to_ws_valid  out  1  MEM output valid
ms_to_ws_bus  out  MS_TO_WS_BUS_WD  {excode, badvaddr, ex, dest, gr_strb, final_result, pc}, MSB first
ms_fwd_dest  out  5  forwarding destination; 0 when no write
ms_fwd_data  out  32  forwarding data
ms_load_block  out  1  valid load whose data has not yet returned
ms_ex_o  out  1  ms_valid & ex

Behaviour:
Reset values:
- ms_valid=0, outstanding=0, drop_cnt=0, rbuf_valid=0.
- Therefore ms_to_ws_valid=0, ms_load_block=0, ms_ex_o=0, ms_fwd_dest=0, ms_req_stall=0.

Pipeline handshake:
- ms_ready_go = ex | !wait_resp | rbuf_valid | own_resp.
- own_resp = data_sram_data_ok & drop_cnt==0 & ms_valid & wait_resp & !rbuf_valid.
- ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
- ms_to_ws_valid = ms_valid & ms_ready_go & !flush.
- flush: ms_valid<=0, rbuf_valid<=0. flush takes priority over a new fill.
- Otherwise, when ms_allowin: ms_valid<=es_to_ms_valid; the bus register loads on es_to_ms_valid & ms_allowin.

Response buffer:
- own_resp while !ws_allowin: capture rdata, rbuf_valid<=1.
- rbuf_valid clears when the instruction moves to WB.
- Result source: rbuf_valid ? rbuf : data_sram_rdata.

Outstanding counter (2 bits):
- +1 on es_req_fire, -1 on data_ok that is not dropped; both in the same cycle leaves it unchanged.
- ms_req_stall = (outstanding==2) | ms_ex_o | flush.
- On flush: drop_cnt <= outstanding, plus es_req_fire this cycle, minus data_ok this cycle; outstanding<=0.
- data_ok with drop_cnt>0: drop_cnt-1, response ignored; never consumed by the next instruction.

Load extraction (off = alu_result[1:0], d = response data, rt = rt_value):
- 0 lw: d.
- 1 lb / 2 lbu: selected byte, sign-/zero-extended.
- 3 lh / 4 lhu: half at off[1], sign-/zero-extended.
- 5 lwl: off0 {d[7:0],rt[23:0]}; off1 {d[15:0],rt[15:0]}; off2 {d[23:0],rt[7:0]}; off3 d.
- 6 lwr: off0 d; off1 {rt[31:24],d[31:8]}; off2 {rt[31:16],d[31:16]}; off3 {rt[31:8],d[31:24]}.
- 7: non-load; final_result = alu_result. Stores set wait_resp=1, load_op=7; the response is consumed and ignored.
- ex=1: no wait; pass excode and badvaddr unchanged; gr_strb passes unchanged (WB masks).

Forwarding:
- ms_fwd_dest = (ms_valid & |gr_strb & !ex) ? dest : 0.
- ms_fwd_data = final_result.
- ms_load_block = ms_valid & load_op!=7 & !ex & !ms_ready_go.

Test Plan:
- lb at alu_result=0x...2, response 0x80FF7F01 after 3 cycles, ws_allowin=1 -> ms_load_block=1 for 3 cycles, then final_result=0xFFFFFFFF with ms_to_ws_valid=1 for one cycle.
- lwl off1, rt=0x11223344, d=0xAABBCCDD -> final 0xCCDD3344; lwr off2 same inputs -> 0x1122AABB.
- Response arrives while ws_allowin=0 for 2 cycles -> buffered; result forwarded unchanged on release; no second data_ok consumed.
- Two requests outstanding, then flush -> drop_cnt=2, next two data_ok ignored; a following lw gets the third response 0x12345678.
- flush in the same cycle as es_req_fire with outstanding=1 -> drop_cnt=2; ms_to_ws_valid=0 that cycle.
- Reset asserted mid-wait -> next cycle ms_valid=0, outstanding=0, all outputs at reset values.

Source files
------------

// File: rtl/mem_stage_if.sv
// EX/MEM/WB handshake, data-response and ID feedback signals of the MEM stage.
// The master side drives EX requests, SRAM responses, WB backpressure and flush; the slave is mem_stage.
interface mem_stage_if #(
    parameter int ES_TO_MS_BUS_WD = 147,
    parameter int MS_TO_WS_BUS_WD = 111
);
    logic                       flush;
    logic                       ms_allowin;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       es_req_fire;
    logic                       ms_req_stall;
    logic                       data_sram_data_ok;
    logic [31:0]                data_sram_rdata;
    logic                       ws_allowin;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic [4:0]                 ms_fwd_dest;
    logic [31:0]                ms_fwd_data;
    logic                       ms_load_block;
    logic                       ms_ex_o;

    modport master (
        output flush, es_to_ms_valid, es_to_ms_bus, es_req_fire,
               data_sram_data_ok, data_sram_rdata, ws_allowin,
        input  ms_allowin, ms_req_stall, ms_to_ws_valid, ms_to_ws_bus,
               ms_fwd_dest, ms_fwd_data, ms_load_block, ms_ex_o
    );

    modport slave (
        input  flush, es_to_ms_valid, es_to_ms_bus, es_req_fire,
               data_sram_data_ok, data_sram_rdata, ws_allowin,
        output ms_allowin, ms_req_stall, ms_to_ws_valid, ms_to_ws_bus,
               ms_fwd_dest, ms_fwd_data, ms_load_block, ms_ex_o
    );
endinterface

// File: rtl/mem_stage.sv
// MIPS MEM stage: waits for data-SRAM responses, extracts load data, feeds WB and ID forwarding.
// One cycle from EX when no response is pending; holds (ms_allowin low) while data is missing or WB blocks.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 147,
    parameter int MS_TO_WS_BUS_WD = 111
) (
    input  logic       clk,
    input  logic       reset,
    mem_stage_if.slave ms_if
);

    typedef struct packed {
        logic [2:0]  load_op;
        logic        wait_resp;
        logic        ex;
        logic [4:0]  excode;
        logic [31:0] badvaddr;
        logic [4:0]  dest;
        logic [3:0]  gr_strb;
        logic [31:0] alu_result;
        logic [31:0] rt_value;
        logic [31:0] pc;
    } es_bus_t;

    typedef struct packed {
        logic [4:0]  excode;
        logic [31:0] badvaddr;
        logic        ex;
        logic [4:0]  dest;
        logic [3:0]  gr_strb;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_bus_t;

    logic        ms_valid_q, ms_valid_d;
    es_bus_t     bus_q, bus_d;
    logic [1:0]  outstanding_q, outstanding_d;
    logic [1:0]  drop_cnt_q, drop_cnt_d;
    logic        rbuf_valid_q, rbuf_valid_d;
    logic [31:0] rbuf_q, rbuf_d;

    logic [ES_TO_MS_BUS_WD-1:0] es_raw;
    es_bus_t     es_in;
    ms_bus_t     ms_out;
    logic        resp_drop;
    logic        resp_keep;
    logic        own_resp;
    logic        ms_ready_go;
    logic        ms_allowin;
    logic        to_ws_valid;
    logic        moves_to_ws;
    logic        ex_o;
    logic [31:0] resp_data;
    logic [31:0] final_result;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [1:0]  off;

    assign es_raw = ms_if.es_to_ms_bus;
    assign es_in  = es_raw;

    // A response is stale while drop_cnt is non-zero: it belongs to a flushed instruction.
    assign resp_drop   = ms_if.data_sram_data_ok & (drop_cnt_q != 2'd0);
    assign resp_keep   = ms_if.data_sram_data_ok & (drop_cnt_q == 2'd0);
    assign own_resp    = resp_keep & ms_valid_q & bus_q.wait_resp & !rbuf_valid_q;
    assign ms_ready_go = bus_q.ex | !bus_q.wait_resp | rbuf_valid_q | own_resp;
    assign ms_allowin  = !ms_valid_q | (ms_ready_go & ms_if.ws_allowin);
    assign to_ws_valid = ms_valid_q & ms_ready_go & !ms_if.flush;
    assign moves_to_ws = to_ws_valid & ms_if.ws_allowin;
    assign ex_o        = ms_valid_q & bus_q.ex;

    always_comb begin
        resp_data    = rbuf_valid_q ? rbuf_q : ms_if.data_sram_rdata;
        off          = bus_q.alu_result[1:0];
        byte_sel     = resp_data[{off, 3'b000} +: 8];
        half_sel     = off[1] ? resp_data[31:16] : resp_data[15:0];
        final_result = bus_q.alu_result;
        case (bus_q.load_op)
            3'd0: final_result = resp_data;
            3'd1: final_result = {{24{byte_sel[7]}}, byte_sel};
            3'd2: final_result = {24'd0, byte_sel};
            3'd3: final_result = {{16{half_sel[15]}}, half_sel};
            3'd4: final_result = {16'd0, half_sel};
            3'd5: begin
                case (off)
                    2'd0:    final_result = {resp_data[7:0],  bus_q.rt_value[23:0]};
                    2'd1:    final_result = {resp_data[15:0], bus_q.rt_value[15:0]};
                    2'd2:    final_result = {resp_data[23:0], bus_q.rt_value[7:0]};
                    default: final_result = resp_data;
                endcase
            end
            3'd6: begin
                case (off)
                    2'd0:    final_result = resp_data;
                    2'd1:    final_result = {bus_q.rt_value[31:24], resp_data[31:8]};
                    2'd2:    final_result = {bus_q.rt_value[31:16], resp_data[31:16]};
                    default: final_result = {bus_q.rt_value[31:8],  resp_data[31:24]};
                endcase
            end
            default: final_result = bus_q.alu_result;
        endcase
    end

    always_comb begin
        ms_valid_d    = ms_valid_q;
        bus_d         = bus_q;
        rbuf_valid_d  = rbuf_valid_q;
        rbuf_d        = rbuf_q;
        outstanding_d = outstanding_q + {1'b0, ms_if.es_req_fire} - {1'b0, resp_keep};
        drop_cnt_d    = drop_cnt_q - {1'b0, resp_drop};
        if (ms_if.flush) begin
            ms_valid_d    = 1'b0;
            rbuf_valid_d  = 1'b0;
            outstanding_d = 2'd0;
            // Everything still in flight, including this cycle's request, must be discarded.
            drop_cnt_d    = drop_cnt_q + outstanding_q + {1'b0, ms_if.es_req_fire}
                          - {1'b0, ms_if.data_sram_data_ok};
        end else begin
            if (ms_allowin) begin
                ms_valid_d = ms_if.es_to_ms_valid;
            end
            if (ms_if.es_to_ms_valid & ms_allowin) begin
                bus_d = es_in;
            end
            if (own_resp & !ms_if.ws_allowin) begin
                rbuf_valid_d = 1'b1;
                rbuf_d       = ms_if.data_sram_rdata;
            end else if (moves_to_ws) begin
                rbuf_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q    <= 1'b0;
            outstanding_q <= 2'd0;
            drop_cnt_q    <= 2'd0;
            rbuf_valid_q  <= 1'b0;
        end else begin
            ms_valid_q    <= ms_valid_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            rbuf_valid_q  <= rbuf_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        bus_q  <= bus_d;
        rbuf_q <= rbuf_d;
    end

    always_comb begin
        ms_out.excode       = bus_q.excode;
        ms_out.badvaddr     = bus_q.badvaddr;
        ms_out.ex           = bus_q.ex;
        ms_out.dest         = bus_q.dest;
        ms_out.gr_strb      = bus_q.gr_strb;
        ms_out.final_result = final_result;
        ms_out.pc           = bus_q.pc;
    end

    assign ms_if.ms_allowin     = ms_allowin;
    assign ms_if.ms_to_ws_valid = to_ws_valid;
    assign ms_if.ms_to_ws_bus   = MS_TO_WS_BUS_WD'(ms_out);
    assign ms_if.ms_ex_o        = ex_o;
    assign ms_if.ms_req_stall   = (outstanding_q == 2'd2) | ex_o | ms_if.flush;
    assign ms_if.ms_fwd_dest    = (ms_valid_q & (|bus_q.gr_strb) & !bus_q.ex) ? bus_q.dest : 5'd0;
    assign ms_if.ms_fwd_data    = final_result;
    assign ms_if.ms_load_block  = ms_valid_q & (bus_q.load_op != 3'd7) & !bus_q.ex & !ms_ready_go;

endmodule
